// File: rtl/char_gen_pkg.sv
// rtl/char_gen_pkg.sv - shared types, defaults and font data for the glyph serializer
//
// Purpose: default glyph geometry, the serializer FSM state type, and the
//          built-in 8x16 digit font ('1'..'4') used by the glyph ROM.
// Ports:   none (package).

package char_gen_pkg;

  localparam int GLYPH_W_DEF    = 8;
  localparam int GLYPH_H_DEF    = 16;
  localparam int NUM_GLYPHS_DEF = 4;
  localparam int MAX_SCALE_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Digit font, row 0 in the most significant byte.
  localparam logic [127:0] FONT_1 = 128'h3878D818_18181818_18181818_1818FF00;
  localparam logic [127:0] FONT_2 = 128'h7EFFC303_060C1830_60C0C0C0_C0FFFF00;
  localparam logic [127:0] FONT_3 = 128'h7EFFE703_033E3E03_030303E7_FF7E0000;
  localparam logic [127:0] FONT_4 = 128'h060E1E36_66C6FFFF_06060606_06060000;

  // One 8-pixel font row; anything outside the stored digits reads blank.
  function automatic logic [7:0] font_row(input int code, input int row);
    logic [127:0] w_glyph;
    case (code)
      0:       w_glyph = FONT_1;
      1:       w_glyph = FONT_2;
      2:       w_glyph = FONT_3;
      3:       w_glyph = FONT_4;
      default: w_glyph = '0;
    endcase
    if (row < 0 || row > 15) begin
      return 8'h00;
    end
    return w_glyph[(15 - row) * 8 +: 8];
  endfunction

endpackage

// File: rtl/char_glyph_rom.sv
// rtl/char_glyph_rom.sv - synchronous-read glyph ROM addressed by {code,row}
//
// Purpose: GLYPH_W x (NUM_GLYPHS*GLYPH_H) glyph store with one registered
//          read cycle. Codes >= NUM_GLYPHS or rows >= GLYPH_H read as 0.
// Ports:
//   inClock  in   1          clock, rising edge
//   i_en     in   1          capture a new read (data holds otherwise)
//   i_code   in   CODE_W+1   glyph code, may be out of range
//   i_row    in   ROW_W      row within glyph
//   o_data   out  GLYPH_W    registered glyph row, MSB = leftmost pixel

module char_glyph_rom
  import char_gen_pkg::*;
#(
  parameter int GLYPH_W    = GLYPH_W_DEF,
  parameter int GLYPH_H    = GLYPH_H_DEF,
  parameter int NUM_GLYPHS = NUM_GLYPHS_DEF,
  parameter int CODE_W     = 2,
  parameter int ROW_W      = 4
) (
  input  logic               inClock,
  input  logic               i_en,
  input  logic [CODE_W:0]    i_code,
  input  logic [ROW_W-1:0]   i_row,
  output logic [GLYPH_W-1:0] o_data
);

  logic [GLYPH_W-1:0] w_word;
  logic [GLYPH_W-1:0] r_data;

  always_comb begin
    w_word = '0;
    if ((int'(i_code) < NUM_GLYPHS) && (int'(i_row) < GLYPH_H)) begin
      w_word = GLYPH_W'(font_row(int'(i_code), int'(i_row)));
    end
  end

  always_ff @(posedge inClock) begin
    if (i_en) begin
      r_data <= w_word;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/char_glyph_serializer.sv
// rtl/char_glyph_serializer.sv - glyph row fetch and scaled MSB-first pixel serializer
//
// Purpose: accepts a (code,row) request, reads the glyph row from the ROM and
//          streams it MSB-first, each source pixel held for `scale` beats,
//          optionally inverted. Ready/valid handshakes on request and pixel side.
// Ports:
//   inClock      in   1         clock, rising edge
//   inResetN     in   1         synchronous active-low reset
//   inReqValid   in   1         request valid
//   outReqReady  out  1         request ready (high only in IDLE)
//   inCode       in   CODE_W+1  glyph code
//   inRow        in   ROW_W     glyph row, 0 = top
//   inScale      in   SCALE_W   beats per source pixel (0 -> 1, clamped to MAX_SCALE)
//   inInvert     in   1         invert emitted pixels
//   outPixValid  out  1         pixel valid
//   inPixReady   in   1         downstream accepts pixel
//   outPixel     out  1         pixel value, 1 = foreground
//   outPixLast   out  1         final pixel of the row

module char_glyph_serializer
  import char_gen_pkg::*;
#(
  parameter  int GLYPH_W    = GLYPH_W_DEF,
  parameter  int GLYPH_H    = GLYPH_H_DEF,
  parameter  int NUM_GLYPHS = NUM_GLYPHS_DEF,
  parameter  int MAX_SCALE  = MAX_SCALE_DEF,
  localparam int CODE_W     = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1,
  localparam int ROW_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
  localparam int SCALE_W    = $clog2(MAX_SCALE + 1)
) (
  input  logic               inClock,
  input  logic               inResetN,
  input  logic               inReqValid,
  output logic               outReqReady,
  input  logic [CODE_W:0]    inCode,
  input  logic [ROW_W-1:0]   inRow,
  input  logic [SCALE_W-1:0] inScale,
  input  logic               inInvert,
  output logic               outPixValid,
  input  logic               inPixReady,
  output logic               outPixel,
  output logic               outPixLast
);

  localparam int BIT_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

  state_t             r_state;
  logic               r_req_ready;
  logic               r_pix_valid;
  logic               r_pix_last;
  logic               r_invert;
  logic [SCALE_W-1:0] r_scale;
  logic [SCALE_W-1:0] r_scale_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [GLYPH_W-1:0] r_shift;

  logic               w_accept;
  logic               w_beat;
  logic               w_adv;
  logic [SCALE_W-1:0] w_next_sc;
  logic [BIT_W-1:0]   w_next_bit;
  logic               w_next_last;
  logic [SCALE_W-1:0] w_scale_eff;
  logic [GLYPH_W-1:0] w_rom_data;

  function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_W-1:0] s);
    if (s == '0) begin
      return SCALE_W'(1);
    end
    if (int'(s) > MAX_SCALE) begin
      return SCALE_W'(MAX_SCALE);
    end
    return s;
  endfunction

  assign w_accept    = inReqValid && r_req_ready;
  assign w_beat      = r_pix_valid && inPixReady;
  assign w_scale_eff = clamp_scale(inScale);

  // A source pixel advances once it has been shown for r_scale beats.
  assign w_adv       = (r_scale_cnt == r_scale - SCALE_W'(1));
  assign w_next_sc   = w_adv ? '0 : r_scale_cnt + SCALE_W'(1);
  assign w_next_bit  = w_adv ? r_bit_cnt + BIT_W'(1) : r_bit_cnt;
  assign w_next_last = (w_next_bit == BIT_W'(GLYPH_W - 1)) &&
                       (w_next_sc == r_scale - SCALE_W'(1));

  // The ROM captures the request address on the accepting edge, so its
  // registered word is ready throughout FETCH and loads at the end of it.
  char_glyph_rom #(
    .GLYPH_W    (GLYPH_W),
    .GLYPH_H    (GLYPH_H),
    .NUM_GLYPHS (NUM_GLYPHS),
    .CODE_W     (CODE_W),
    .ROW_W      (ROW_W)
  ) u_rom (
    .inClock (inClock),
    .i_en    (w_accept),
    .i_code  (inCode),
    .i_row   (inRow),
    .o_data  (w_rom_data)
  );

  always_ff @(posedge inClock) begin
    if (!inResetN) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_invert    <= 1'b0;
      r_scale     <= SCALE_W'(1);
      r_scale_cnt <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_scale     <= w_scale_eff;
            r_invert    <= inInvert;
            r_req_ready <= 1'b0;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_shift     <= w_rom_data ^ {GLYPH_W{r_invert}};
          r_scale_cnt <= '0;
          r_bit_cnt   <= '0;
          r_pix_valid <= 1'b1;
          r_pix_last  <= (GLYPH_W == 1) && (r_scale == SCALE_W'(1));
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_beat) begin
            if (r_pix_last) begin
              // Clearing the shift register keeps outPixel at 0 while idle.
              r_pix_valid <= 1'b0;
              r_pix_last  <= 1'b0;
              r_shift     <= '0;
              r_req_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_scale_cnt <= w_next_sc;
              r_bit_cnt   <= w_next_bit;
              r_pix_last  <= w_next_last;
              if (w_adv) begin
                r_shift <= r_shift << 1;
              end
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_pix_valid <= 1'b0;
          r_pix_last  <= 1'b0;
          r_shift     <= '0;
        end
      endcase
    end
  end

  assign outReqReady = r_req_ready;
  assign outPixValid = r_pix_valid;
  assign outPixLast  = r_pix_last;
  assign outPixel    = r_shift[GLYPH_W-1];

endmodule
